// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB Moore FSM driving datapath selects and a
// shared memory port; memory phases stall on mem_ready, unsupported opcodes park in TRAP until reset.
module multi_cycle_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  opcode,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_is_fetch,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [2:0]  state_o,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;

   state_t state, state_nxt;
   logic   is_load, is_store, is_branch, is_lui, is_rtype, is_ialu, supported;
   logic   retire;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_lui    = (opcode == OP_LUI);
   assign is_rtype  = (opcode == OP_RTYPE);
   assign is_ialu   = (opcode == OP_IALU);
   assign supported = is_load | is_store | is_branch | is_lui | is_rtype | is_ialu;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_INIT;
         retired <= 32'd0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (retire)
            retired <= retired + 32'd1;
         if (state == S_DECODE && !supported)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = 2'b00;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
      case (state)
         S_INIT: state_nxt = S_FETCH;
         S_FETCH: begin
            mem_req      = 1'b1;
            mem_is_fetch = 1'b1;
            if (mem_ready) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: state_nxt = supported ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_branch) begin
               alu_op    = 2'b01;
               // Taken branch overwrites the PC+4 already written during FETCH
               pc_we     = br_taken;
               pc_sel    = br_taken;
               state_nxt = S_FETCH;
            end else if (is_load || is_store) begin
               alu_src_b = 1'b1;
               state_nxt = S_MEM;
            end else if (is_rtype) begin
               alu_op    = 2'b10;
               state_nxt = S_WB;
            end else if (is_ialu) begin
               alu_src_b = 1'b1;
               alu_op    = 2'b10;
               state_nxt = S_WB;
            end else if (is_lui) begin
               state_nxt = S_WB;
            end else begin
               state_nxt = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (mem_ready)
               state_nxt = is_store ? S_FETCH : S_WB;
         end
         S_WB: begin
            reg_we    = 1'b1;
            wb_sel    = is_load ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
            state_nxt = S_FETCH;
         end
         S_TRAP: state_nxt = S_TRAP;
         default: state_nxt = S_INIT;
      endcase
   end

   assign retire  = (state_nxt == S_FETCH) &&
                    (state == S_EXEC || state == S_MEM || state == S_WB);
   assign state_o = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class state by state against hand tables.
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [6:0]  opcode = 7'h00;
   logic        br_taken = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_src_b, reg_we;
   logic [1:0]  alu_op, wb_sel;
   logic        illegal;
   logic [2:0]  state_o;
   logic [31:0] retired;
   logic [11:0] ctl;
   logic [31:0] exp_ret = 32'd0;
   int          n_vec = 0;
   int          n_err = 0;

   multi_cycle_ctrl dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
      .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o), .retired(retired)
   );

   // {req, we, is_fetch, ir_we, pc_we, pc_sel, src_b, alu_op[1:0], reg_we, wb_sel[1:0]}
   assign ctl = {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_src_b, alu_op, reg_we, wb_sel};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({state_o, ctl, illegal, retired} !== {3'd0, 12'd0, 1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_hold: state=%0d ctl=%b illegal=%b retired=%0d, expected 0/0/0/0", state_o, ctl, illegal, retired);
      end
      reset_n = 1'b1;
      #1;
      n_vec++;
      if ({state_o, ctl, retired} !== {3'd0, 12'd0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_release: state=%0d ctl=%b retired=%0d, expected 0/0/0", state_o, ctl, retired);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({state_o, ctl} !== {3'd1, 12'b101000000000}) begin
            n_err++;
            $display("FAIL first_fetch_wait %0d: state=%0d ctl=%b, expected 1 %b", i, state_o, ctl, 12'b101000000000);
         end
         tick();
      end
   endtask

   task automatic test_rtype();
      logic [2:0]  es [4];
      logic [11:0] ec [4];
      es = '{3'd1, 3'd2, 3'd3, 3'd5};
      ec = '{12'b101110000000, 12'b000000000000, 12'b000000010000, 12'b000000000100};
      opcode = 7'h33; br_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1; #1;
         n_vec++;
         if ({state_o, ctl, retired} !== {es[i], ec[i], exp_ret}) begin
            n_err++;
            $display("FAIL rtype step %0d: state=%0d ctl=%b retired=%0d, expected %0d %b %0d", i, state_o, ctl, retired, es[i], ec[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      n_vec++;
      if (state_o !== 3'd1 || retired !== exp_ret) begin
         n_err++;
         $display("FAIL rtype retire: state=%0d retired=%0d, expected 1 %0d", state_o, retired, exp_ret);
      end
   endtask

   task automatic test_ialu();
      logic [2:0]  es [4];
      logic [11:0] ec [4];
      es = '{3'd1, 3'd2, 3'd3, 3'd5};
      ec = '{12'b101110000000, 12'b000000000000, 12'b000000110000, 12'b000000000100};
      opcode = 7'h13; br_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1; #1;
         n_vec++;
         if ({state_o, ctl, retired} !== {es[i], ec[i], exp_ret}) begin
            n_err++;
            $display("FAIL ialu step %0d: state=%0d ctl=%b retired=%0d, expected %0d %b %0d", i, state_o, ctl, retired, es[i], ec[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      n_vec++;
      if (state_o !== 3'd1 || retired !== exp_ret) begin
         n_err++;
         $display("FAIL ialu retire: state=%0d retired=%0d, expected 1 %0d", state_o, retired, exp_ret);
      end
   endtask

   task automatic test_load_wait();
      logic [2:0]  es [7];
      logic [11:0] ec [7];
      logic        rd [7];
      es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
      ec = '{12'b101110000000, 12'b000000000000, 12'b000000100000, 12'b100000000000,
             12'b100000000000, 12'b100000000000, 12'b000000000101};
      rd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      opcode = 7'h03; br_taken = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rd[i]; #1;
         n_vec++;
         if ({state_o, ctl, retired} !== {es[i], ec[i], exp_ret}) begin
            n_err++;
            $display("FAIL load step %0d: state=%0d ctl=%b retired=%0d, expected %0d %b %0d", i, state_o, ctl, retired, es[i], ec[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      n_vec++;
      if (state_o !== 3'd1 || retired !== exp_ret) begin
         n_err++;
         $display("FAIL load retire: state=%0d retired=%0d, expected 1 %0d", state_o, retired, exp_ret);
      end
   endtask

   task automatic test_store_lui();
      logic [2:0]  es [9];
      logic [11:0] ec [9];
      logic [6:0]  eo [9];
      logic        rd [9];
      // Store with one FETCH wait cycle, then LUI back to back
      es = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5};
      ec = '{12'b101000000000, 12'b101110000000, 12'b000000000000, 12'b000000100000,
             12'b110000000000, 12'b101110000000, 12'b000000000000, 12'b000000000000,
             12'b000000000110};
      eo = '{7'h23, 7'h23, 7'h23, 7'h23, 7'h23, 7'h37, 7'h37, 7'h37, 7'h37};
      rd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      br_taken = 1'b1;
      for (int i = 0; i < 9; i++) begin
         opcode = eo[i]; mem_ready = rd[i]; #1;
         n_vec++;
         if ({state_o, ctl, retired} !== {es[i], ec[i], exp_ret}) begin
            n_err++;
            $display("FAIL store_lui step %0d: state=%0d ctl=%b retired=%0d, expected %0d %b %0d", i, state_o, ctl, retired, es[i], ec[i], exp_ret);
         end
         tick();
         if (i == 4) exp_ret++;
      end
      exp_ret++;
      n_vec++;
      if (state_o !== 3'd1 || retired !== exp_ret) begin
         n_err++;
         $display("FAIL store_lui retire: state=%0d retired=%0d, expected 1 %0d", state_o, retired, exp_ret);
      end
   endtask

   task automatic test_branch(input logic taken);
      logic [2:0]  es [3];
      logic [11:0] ec [3];
      es = '{3'd1, 3'd2, 3'd3};
      ec = '{12'b101110000000, 12'b000000000000, taken ? 12'b000011001000 : 12'b000000001000};
      opcode = 7'h63;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         br_taken = (i == 2) ? taken : ~taken;
         #1;
         n_vec++;
         if ({state_o, ctl, retired} !== {es[i], ec[i], exp_ret}) begin
            n_err++;
            $display("FAIL branch(taken=%0b) step %0d: state=%0d ctl=%b retired=%0d, expected %0d %b %0d", taken, i, state_o, ctl, retired, es[i], ec[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      n_vec++;
      if (state_o !== 3'd1 || retired !== exp_ret) begin
         n_err++;
         $display("FAIL branch(taken=%0b) retire: state=%0d retired=%0d, expected 1 %0d", taken, state_o, retired, exp_ret);
      end
   endtask

   task automatic test_trap();
      opcode = 7'h73; mem_ready = 1'b1; br_taken = 1'b0;
      tick();
      n_vec++;
      if ({state_o, illegal} !== {3'd2, 1'b0}) begin
         n_err++;
         $display("FAIL trap_decode: state=%0d illegal=%b, expected 2 0", state_o, illegal);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom_range(1, 0));
         #1;
         n_vec++;
         if ({state_o, ctl, illegal, retired} !== {3'd7, 12'd0, 1'b1, exp_ret}) begin
            n_err++;
            $display("FAIL trap_hold %0d: state=%0d ctl=%b illegal=%b retired=%0d, expected 7 0 1 %0d", i, state_o, ctl, illegal, retired, exp_ret);
         end
         tick();
      end
      reset_n = 1'b0;
      #1;
      exp_ret = 32'd0;
      n_vec++;
      if ({state_o, ctl, illegal, retired} !== {3'd0, 12'd0, 1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL trap_reset: state=%0d ctl=%b illegal=%b retired=%0d, expected 0 0 0 0", state_o, ctl, illegal, retired);
      end
      reset_n = 1'b1;
      mem_ready = 1'b0;
      tick();
      n_vec++;
      if ({state_o, ctl} !== {3'd1, 12'b101000000000}) begin
         n_err++;
         $display("FAIL trap_refetch: state=%0d ctl=%b, expected 1 %b", state_o, ctl, 12'b101000000000);
      end
   endtask

   task automatic test_reset_mid_access();
      // Run a load into MEM, then pull reset while the data request is outstanding
      opcode = 7'h03; mem_ready = 1'b1;
      tick(); tick(); mem_ready = 1'b0; tick();
      #1;
      n_vec++;
      if ({state_o, mem_req} !== {3'd4, 1'b1}) begin
         n_err++;
         $display("FAIL mid_access_pre: state=%0d mem_req=%b, expected 4 1", state_o, mem_req);
      end
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({state_o, ctl, retired} !== {3'd0, 12'd0, 32'd0}) begin
         n_err++;
         $display("FAIL mid_access_reset: state=%0d ctl=%b retired=%0d, expected 0 0 0", state_o, ctl, retired);
      end
      mem_ready = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
      n_vec++;
      if ({state_o, retired} !== {3'd1, 32'd0}) begin
         n_err++;
         $display("FAIL mid_access_restart: state=%0d retired=%0d, expected 1 0", state_o, retired);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_ialu();
      test_load_wait();
      test_store_lui();
      test_branch(1'b1);
      test_branch(1'b0);
      test_trap();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore-style control FSM that sequences the multi-cycle RV32I datapath: instruction fetch, decode (register read and immediate generation), execute, memory access and write-back. It drives PC/IR enables, ALU operand and operation selects, the write-back mux and a shared instruction/data memory port with a request/ready handshake. It covers the same opcode subset as the immediate generator plus R-type and I-type ALU instructions. It also flags unsupported opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0], stable from DECODE until the next FETCH completes
- br_taken  in  1  branch comparator result, sampled in EXEC
- mem_ready  in  1  memory accepted/completed the current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (store), 0 = read
- mem_is_fetch  out  1  memory address mux: 1 = PC, 0 = ALU result
- ir_we  out  1  load IR and old_pc (old_pc = PC of fetched instruction)
- pc_we  out  1  PC write enable
- pc_sel  out  1  0 = PC+4, 1 = old_pc + Imm_out
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 subtract/compare, 10 decoded from funct3/funct7
- reg_we  out  1  register file write enable
- wb_sel  out  2  00 ALU, 01 memory read data, 10 immediate (LUI)
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  3  current state (debug)
- retired  out  32  retired-instruction counter

## Operation
- States and encodings: INIT = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7.
- Outputs not listed for a state are 0.
- Supported opcodes:
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - LUI 0110111
  - R-type 0110011
  - I-ALU 0010011
- INIT: all outputs 0. Next state is FETCH.
- FETCH: mem_req = 1, mem_is_fetch = 1.
  - While mem_ready = 0: stay in FETCH.
  - On mem_ready = 1: ir_we = 1, pc_we = 1, pc_sel = 0, next state DECODE.
- DECODE: no control outputs asserted.
  - Supported opcode: go to EXEC.
  - Any other opcode: go to TRAP and set illegal.
- EXEC, by opcode:
  - BRANCH: alu_op = 01. If br_taken: pc_we = 1, pc_sel = 1. Next state FETCH (retire).
  - LOAD/STORE: alu_src_b = 1, alu_op = 00. Next state MEM.
  - R-type: alu_src_b = 0, alu_op = 10. Next state WB.
  - I-ALU: alu_src_b = 1, alu_op = 10. Next state WB.
  - LUI: no ALU outputs. Next state WB.
- MEM: mem_req = 1, mem_is_fetch = 0, mem_we = (opcode == STORE).
  - Stay in MEM until mem_ready.
  - On mem_ready: STORE goes to FETCH (retire); LOAD goes to WB.
- WB: reg_we = 1. wb_sel = 01 for LOAD, 10 for LUI, 00 otherwise. Next state FETCH (retire).
- TRAP: all control outputs 0, illegal = 1. Exited only by reset.
- Retire: retired increments by 1 on each transition into FETCH from EXEC, MEM or WB.
  - 32-bit counter; wraps 0xFFFFFFFF → 0.
  - Never increments in INIT, on entry into TRAP, or while in TRAP.

## Timing
- All outputs except retired and illegal are combinational decodes of the registered state and opcode. No output depends on mem_ready except ir_we and pc_we in FETCH, and the MEM exit transition.
- Reset (asynchronous, immediate): state = INIT, retired = 0, illegal = 0. Every output reads 0 during and immediately after reset.
- Reset asserted mid-access: mem_req drops in the same instant. The pending access is abandoned and not retired.
- Handshake: while mem_req = 1, mem_we and mem_is_fetch are held constant. A transfer completes on the clock edge where mem_req = 1 and mem_ready = 1. mem_ready while mem_req = 0 is ignored.
- Cycles per instruction with zero wait states, counted from FETCH entry to next FETCH entry:
  - BRANCH: 3
  - STORE: 4
  - R-type, I-ALU, LUI: 4
  - LOAD: 5
- Each memory wait cycle adds 1 cycle.
- First FETCH occurs 1 cycle after reset_n deasserts.
- Branch decision uses br_taken sampled only in the EXEC cycle; pc_we in EXEC overrides the PC+4 written in FETCH.

## Test plan
- Reset: hold reset_n = 0, then release → state_o = 0, all outputs 0, retired = 0. Next cycle state_o = 1, mem_req = 1, mem_is_fetch = 1.
- R-type 0x002081B3 with mem_ready tied to 1 → states 1, 2, 3, 5, 1. alu_op = 10 in EXEC. reg_we = 1 and wb_sel = 00 in WB. retired = 1 after 4 cycles.
- LOAD with 2 wait cycles in MEM → MEM holds 3 cycles with mem_req = 1, mem_we = 0. Then WB with wb_sel = 01. Total 7 cycles.
- STORE then LUI → STORE: mem_we = 1 in MEM, FETCH next, reg_we never asserted. LUI: wb_sel = 10. retired = 2.
- BRANCH with br_taken = 1, then with br_taken = 0 → pc_we = 1, pc_sel = 1 in EXEC for the first; pc_we = 0 in EXEC for the second. Each is 3 cycles.
- Opcode 0x73 in DECODE → state_o = 7, illegal = 1 held for 20 cycles with mem_req = 0 and retired unchanged. reset_n pulse → illegal = 0, state_o = 0.
